// File: rtl/stencil_sched_ctrl.sv
// stencil_sched_ctrl: raster frame sequencer and pipeline advance for cascaded 3x3 stencils.
// Optional feature: define STENCIL_SCHED_PERF_EN to add a sink-stall cycle counter on stall_cnt.
module stencil_sched_ctrl #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int STAGES = 2,
    parameter int LAT    = 1,
    parameter int CW     = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          pipe_en,
    output logic [CW-1:0] col,
    output logic [CW-1:0] row,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic [31:0]   stall_cnt
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam int FW = LAT > 1 ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [CW-1:0] ROW_MAX = CW'(IMG_H - 1);
    localparam logic [CW-1:0] TAG_MIN = CW'(2 * STAGES);
    localparam logic [FW-1:0] FL_MAX  = FW'(LAT - 1);

    logic [1:0]     state;
    logic [LAT-1:0] tags;
    logic [FW-1:0]  fcnt;
    logic           hold, run, flush, col_end, last_px, tag;

    assign out_valid = tags[LAT-1];
    assign hold      = out_valid & ~out_ready;
    assign run       = state == RUN;
    assign flush     = state == FLUSH;
    assign in_ready  = run & ~hold;
    assign pipe_en   = ((run & in_valid) | flush) & ~hold;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    assign col_end   = col == COL_MAX;
    assign last_px   = col_end & (row == ROW_MAX);
    assign tag       = run & (col >= TAG_MIN) & (row >= TAG_MIN);

    // Frame FSM, raster position, flush count and the window-tag pipe that mirrors the datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
            tags  <= '0;
            fcnt  <= '0;
        end else begin
            if (pipe_en) tags <= LAT'({tags, tag});
            if (state == IDLE && start) state <= RUN;
            if (run && pipe_en) begin
                col <= col_end ? '0 : col + 1'b1;
                row <= last_px ? '0 : col_end ? row + 1'b1 : row;
                if (last_px) state <= FLUSH;
            end
            if (flush && pipe_en) begin
                fcnt <= fcnt + 1'b1;
                if (fcnt == FL_MAX) begin
                    state <= DONE;
                    fcnt  <= '0;
                end
            end
            if (done) begin
                state <= IDLE;
                col   <= '0;
                row   <= '0;
                fcnt  <= '0;
            end
        end
    end

`ifdef STENCIL_SCHED_PERF_EN
    logic [31:0] stalls;

    // Saturating count of cycles the sink held the pipeline during a frame
    always_ff @(posedge clk) begin
        if (reset || (state == IDLE && start)) stalls <= '0;
        else if ((run | flush) & hold & ~&stalls) stalls <= stalls + 1'b1;
    end

    assign stall_cnt = stalls;
`else
    assign stall_cnt = '0;
`endif
endmodule

// File: doc/stencil_sched_ctrl.md
# stencil_sched_ctrl

Frame sequencer for the cascaded 3x3 stencil pipeline (input register → line buffer → conv → line buffer → output). It accepts one pixel per handshake, tracks raster column/row, and drives a single pipeline advance enable for every register and unified-buffer clock enable. It tags which accepted pixels complete a valid window through all stages and flushes the pipeline at end of frame. It sits between the stream source/sink and the free-running datapath; backpressure from the sink stalls the whole pipeline.

## Interface
- IMG_W, 64, frame width in pixels (≥ 2*STAGES+1)
- IMG_H, 64, frame height in rows (≥ 2*STAGES+1)
- STAGES, 2, number of cascaded 3x3 stencil stages (1..4)
- LAT, 1, pipe_en advances from pixel acceptance until its window result appears at the datapath output (1..8)
- CW, 16, column/row counter width
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a frame when idle
- in_valid  in  1  source has a pixel
- in_ready  out  1  controller accepts the pixel this cycle
- pipe_en  out  1  datapath advance; drives every pipeline register and ub clk_en
- col  out  CW  column of the pixel offered this cycle
- row  out  CW  row of the pixel offered this cycle
- out_valid  out  1  datapath output holds a valid window result
- out_ready  in  1  sink accepts the result
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse on frame completion
- stall_cnt  out  32  sink-stall cycle counter (see Configuration)

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: in_ready=0, pipe_en=0, col=row=0. On start → RUN. start is ignored in every other state.
- hold = out_valid & !out_ready.
- RUN: in_ready = !hold; pipe_en = in_valid & !hold (accept). On accept: col++. When col==IMG_W-1, col wraps to 0 and row++. An accept at (IMG_W-1, IMG_H-1) → FLUSH.
- Window tag of an accepted pixel = (col ≥ 2*STAGES) & (row ≥ 2*STAGES).
- Tag shift register, depth LAT, all-zero at reset: on every pipe_en it shifts in the tag (RUN) or 0 (FLUSH). out_valid = last stage.
- FLUSH: in_ready=0; pipe_en = !hold; flush counter 0..LAT-1 increments per pipe_en. The advance with counter == LAT-1 → DONE; the shift register is then all-zero.
- DONE: done=1 for exactly one cycle, counters cleared → IDLE.
- Results per frame = (IMG_W-2*STAGES)*(IMG_H-2*STAGES). Every result is presented exactly once and held stable, with out_valid=1, until out_ready.
- Counters are unsigned CW-bit. IMG_W-1 and IMG_H-1 must fit in CW; no other overflow is possible.

## Timing
- Reset values: state IDLE, col=row=0, shift register 0, flush counter 0, in_ready=pipe_en=out_valid=busy=done=0, stall_cnt=0.
- in_ready and pipe_en are combinational from state, in_valid, out_valid and out_ready. No registered delay is allowed: the datapath must advance in the same cycle as the handshake.
- start → busy=1 and in_ready able to be 1 the next cycle.
- The result of an accepted tagged pixel shows out_valid=1 after LAT-1 further pipe_en advances. For LAT=1 this is the cycle after acceptance.
- Simultaneous in_valid and hold: no accept, no advance, col/row unchanged.
- out_ready asserted while out_valid=1 in the same cycle as an accept: the current result is consumed and the new tag shifts in.
- reset asserted mid-frame: IDLE on the next edge, and the shift register is cleared. done is not pulsed.
- Final accept → FLUSH for at least LAT cycles (more if held) → DONE (1 cycle) → IDLE.

## Configuration
- STENCIL_SCHED_PERF_EN defined: stall_cnt increments (saturating at 2^32-1) each cycle in RUN or FLUSH with hold=1. It clears on reset and on start.
- Not defined: stall_cnt is tied to 0 and no counter logic is synthesized. All other behaviour is identical.

## Test plan
- IMG_W=8, IMG_H=6, STAGES=2, LAT=1; start, in_valid and out_ready held 1 → 48 accepts in 48 consecutive cycles, exactly 8 out_valid pulses. The first appears the cycle after accept of (4,4). done comes 2 cycles after the last accept.
- Same config, out_ready low for 5 cycles while out_valid=1 → in_ready=pipe_en=0 for those 5 cycles, col/row frozen, out_valid held, still 8 results total.
- in_valid toggling 1010… → pipe_en follows in_valid. col wraps 7→0 with row++ only on accepts.
- LAT=3 → FLUSH issues 3 pipe_en advances. The last result appears on the 2nd flush advance. done pulses once, then busy=0.
- reset asserted at (3,2) mid-frame → next cycle busy=0, out_valid=0, col=row=0, no done. A new start runs a full correct frame.
- With STENCIL_SCHED_PERF_EN, 5 held cycles → stall_cnt=5. Without the macro → stall_cnt=0.
